// File: rtl/strobe_divider_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : strobe_pkg
//  Description : Shared mode encodings and one-shot state type for the
//                runtime-programmable strobe divider.
//  Revision    : 1.0 - initial release
// ============================================================================
package strobe_pkg;

    // Operating mode encodings carried on the 2-bit mode input
    localparam logic [1:0] MODE_PULSE    = 2'd0;
    localparam logic [1:0] MODE_SQUARE   = 2'd1;
    localparam logic [1:0] MODE_ONESHOT  = 2'd2;
    localparam logic [1:0] MODE_RESERVED = 2'd3;  // decoded as PULSE

    // One-shot controller states
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } oneshot_state_t;

endpackage
`default_nettype wire

// File: rtl/strobe_divider_if.sv
`default_nettype none
// ============================================================================
//  Module      : strobe_divider_if
//  Description : Control/status bundle of the strobe divider. The master side
//                programs and triggers the divider, the slave side is the
//                divider itself.
//  Revision    : 1.0 - initial release
// ============================================================================
interface strobe_divider_if #(
    parameter int WIDTH = 16
);
    logic             enable;
    logic [1:0]       mode;
    logic [WIDTH-1:0] div_in;
    logic             div_load;
    logic             start;
    logic             sync;
    logic             strobe;
    logic             square;
    logic             busy;
    logic [WIDTH-1:0] div_cur;

    modport master (
        output enable, mode, div_in, div_load, start, sync,
        input  strobe, square, busy, div_cur
    );

    modport slave (
        input  enable, mode, div_in, div_load, start, sync,
        output strobe, square, busy, div_cur
    );
endinterface
`default_nettype wire

// File: rtl/strobe_divider_div_counter.sv
`default_nettype none
// ============================================================================
//  Module      : div_counter
//  Description : Down-counter with synchronous reload and a zero (terminal
//                count) flag. Saturates at zero rather than wrapping.
//  Revision    : 1.0 - initial release
// ============================================================================
module div_counter #(
    parameter int WIDTH = 16
) (
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic             i_load,
    input  wire logic [WIDTH-1:0] i_load_val,
    input  wire logic             i_dec,
    output logic      [WIDTH-1:0] o_count,
    output logic                  o_zero
);

    localparam logic [WIDTH-1:0] c_one = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_count;

    // Reload has priority over decrement; a decrement at zero is dropped
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - c_one;
        end
    end

    assign o_count = r_count;
    assign o_zero  = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/strobe_divider.sv
`default_nettype none
// ============================================================================
//  Module      : strobe_divider
//  Description : Runtime-programmable strobe / clock-enable generator with
//                glitch-free divisor update, enable hold, phase resync,
//                ~50% square output and a one-shot mode.
//  Revision    : 1.0 - initial release
// ============================================================================
module strobe_divider
    import strobe_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int DEFAULT_DIV = 2
) (
    input  wire logic       clk,
    input  wire logic       reset,
    strobe_divider_if.slave bus
);

    localparam logic [WIDTH-1:0] c_one         = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] c_default_div = WIDTH'(DEFAULT_DIV);

    // A divisor of zero behaves exactly like a divisor of one
    function automatic logic [WIDTH-1:0] eff_div(input logic [WIDTH-1:0] d);
        eff_div = (d == '0) ? c_one : d;
    endfunction

    // Registered state
    oneshot_state_t   r_state;
    logic [WIDTH-1:0] r_div_cur;
    logic [WIDTH-1:0] r_pending;
    logic             r_pend_valid;
    logic             r_strobe;
    logic             r_square;

    // Counter interface
    logic [WIDTH-1:0] w_count;
    logic             w_cnt_zero;

    // Edge decisions
    logic             w_oneshot;
    logic             w_running;
    logic             w_tc;
    logic             w_start;
    logic             w_reload;
    logic             w_dec;
    logic [WIDTH-1:0] w_div_next;
    logic [WIDTH-1:0] w_neff_next;
    logic [WIDTH-1:0] w_load_val;
    logic [WIDTH-1:0] w_count_next;
    logic [WIDTH-1:0] w_neff_period;
    logic             w_square_next;

    // Decide, for this edge, whether the counter reloads, decrements or holds,
    // and precompute the square level that matches the post-edge count.
    always_comb begin
        w_oneshot = (bus.mode == MODE_ONESHOT);
        w_running = (r_state == RUN);

        // Terminal count: natural zero or a forced resync. In one-shot mode
        // only a running countdown can terminate; IDLE ignores sync.
        w_tc      = bus.enable && (w_cnt_zero || bus.sync) && (!w_oneshot || w_running);
        w_start   = bus.enable && w_oneshot && !w_running && bus.start;
        w_reload  = w_tc || w_start;
        w_dec     = bus.enable && !w_reload && (!w_oneshot || w_running);

        // A staged divisor only ever takes effect at a reload, so a period
        // in progress always completes with the divisor it started with.
        w_div_next  = r_pend_valid ? r_pending : r_div_cur;
        w_neff_next = eff_div(w_div_next);
        w_load_val  = w_neff_next - c_one;

        if (w_reload) begin
            w_count_next  = w_load_val;
            w_neff_period = w_neff_next;
        end else begin
            w_count_next  = (w_dec && !w_cnt_zero) ? (w_count - c_one) : w_count;
            w_neff_period = eff_div(r_div_cur);
        end

        // High for the first ceil(N/2) counts of each period (count N-1 down
        // to floor(N/2)), so the rising edge lines up with the strobe.
        w_square_next = (w_count_next >= (w_neff_period >> 1));
    end

    div_counter #(
        .WIDTH (WIDTH)
    ) u_counter (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_reload),
        .i_load_val (w_load_val),
        .i_dec      (w_dec),
        .o_count    (w_count),
        .o_zero     (w_cnt_zero)
    );

    // Divisor staging: latch requests at any time, commit them on reload.
    // A load on the same edge as a reload stays pending for the next one.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_div_cur    <= c_default_div;
            r_pending    <= c_default_div;
            r_pend_valid <= 1'b0;
        end else begin
            if (w_reload && r_pend_valid) begin
                r_div_cur <= r_pending;
            end
            if (bus.div_load) begin
                r_pending    <= bus.div_in;
                r_pend_valid <= 1'b1;
            end else if (w_reload) begin
                r_pend_valid <= 1'b0;
            end
        end
    end

    // One-shot FSM and registered strobe/square shaping; disable freezes all
    // but the strobe, which is forced low.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_strobe <= 1'b0;
            r_square <= 1'b0;
        end else if (!bus.enable) begin
            r_strobe <= 1'b0;
        end else begin
            r_strobe <= w_tc;
            if (w_oneshot) begin
                r_square <= 1'b0;
                if (w_start) begin
                    r_state <= RUN;
                end else if (w_tc) begin
                    r_state <= IDLE;
                end
            end else begin
                // Periodic modes keep the FSM parked so entering one-shot
                // always begins from IDLE.
                r_square <= w_square_next;
                r_state  <= IDLE;
            end
        end
    end

    assign bus.strobe  = r_strobe;
    assign bus.square  = r_square;
    assign bus.busy    = w_oneshot ? w_running : bus.enable;
    assign bus.div_cur = r_div_cur;

endmodule
`default_nettype wire

// File: tb/tb_strobe_divider.sv
`default_nettype none
// ============================================================================
//  Module      : tb_strobe_divider
//  Description : Self-checking bench for strobe_divider: a period/phase model
//                checked every cycle plus directed hand-computed sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_strobe_divider;
    import strobe_pkg::*;

    localparam int WIDTH = 16;
    localparam int DEF   = 2;

    logic clk = 1'b0;
    logic reset;

    strobe_divider_if #(.WIDTH(WIDTH)) bus ();

    strobe_divider #(
        .WIDTH       (WIDTH),
        .DEFAULT_DIV (DEF)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Model: tracks the period length in force and how many enabled
    // cycles of that period have elapsed (age). A period ends after
    // Neff cycles; square is high during the first ceil(Neff/2) of them.
    // ------------------------------------------------------------------
    int m_per, m_age, m_div, m_pend;
    bit m_pv, m_run, m_valid;
    bit e_strobe, e_square;

    function automatic int eff(input int d);
        return (d == 0) ? 1 : d;
    endfunction

    initial m_valid = 1'b0;

    always @(posedge clk) begin
        bit os, fire, reload;
        if (reset) begin
            m_div    = DEF;
            m_pend   = DEF;
            m_pv     = 1'b0;
            m_per    = eff(DEF);
            m_age    = m_per - 1;   // first enabled cycle ends a period
            m_run    = 1'b0;
            e_strobe = 1'b0;
            e_square = 1'b0;
            m_valid  = 1'b1;
        end else begin
            os     = (bus.mode == MODE_ONESHOT);
            fire   = 1'b0;
            reload = 1'b0;
            if (bus.enable) begin
                if (!os) begin
                    m_run  = 1'b0;
                    fire   = bus.sync || (m_age == m_per - 1);
                    reload = fire;
                end else if (!m_run) begin
                    if (bus.start) begin
                        m_run  = 1'b1;
                        reload = 1'b1;
                    end
                end else begin
                    fire = bus.sync || (m_age == m_per - 1);
                    if (fire) begin
                        m_run  = 1'b0;
                        reload = 1'b1;
                    end
                end
                if (reload) begin
                    if (m_pv) m_div = m_pend;
                    m_pv  = 1'b0;
                    m_per = eff(m_div);
                    m_age = 0;
                end else if (!os || m_run) begin
                    m_age = m_age + 1;
                end
                e_strobe = fire;
                e_square = os ? 1'b0 : (m_age < (m_per + 1) / 2);
            end else begin
                e_strobe = 1'b0;
            end
            if (bus.div_load) begin
                m_pend = bus.div_in;
                m_pv   = 1'b1;
            end
        end
    end

    // Every-cycle comparison against the model
    always @(posedge clk) begin
        #1;
        if (m_valid) begin
            check("model strobe", bus.strobe, e_strobe);
            check("model square", bus.square, e_square);
            check("model busy", bus.busy, (bus.mode == MODE_ONESHOT) ? m_run : bus.enable);
            check("model div_cur", bus.div_cur, m_div);
        end
    end

    // ------------------------------------------------------------------
    // Directed stimulus; inputs change on the falling edge
    // ------------------------------------------------------------------
    task automatic check_seq(input string name, input int n,
                             input logic [15:0] sp, input logic [15:0] qp);
        for (int i = 0; i < n; i++) begin
            if (i > 0) @(negedge clk);
            check({name, " strobe"}, bus.strobe, sp[i]);
            check({name, " square"}, bus.square, qp[i]);
        end
    endtask

    // Stage a divisor, then resync so it takes effect at once
    task automatic set_div(input int n);
        bus.div_in   = n[WIDTH-1:0];
        bus.div_load = 1'b1;
        @(negedge clk);
        bus.div_load = 1'b0;
        bus.sync     = 1'b1;
        @(negedge clk);
        bus.sync     = 1'b0;
        check("set_div strobe", bus.strobe, 1);
        check("set_div div_cur", bus.div_cur, n);
    endtask

    initial begin
        reset        = 1'b1;
        bus.enable   = 1'b0;
        bus.mode     = MODE_PULSE;
        bus.div_in   = '0;
        bus.div_load = 1'b0;
        bus.start    = 1'b0;
        bus.sync     = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        check("reset strobe", bus.strobe, 0);
        check("reset square", bus.square, 0);
        check("reset busy", bus.busy, 0);
        check("reset div_cur", bus.div_cur, DEF);

        // Default divisor 2: strobe on every other cycle from the first
        reset      = 1'b0;
        bus.enable = 1'b1;
        @(negedge clk);
        check_seq("pulse N2", 8, 16'b0101_0101, 16'b0101_0101);
        check("pulse N2 div_cur", bus.div_cur, 2);

        // N=5, then N=3 staged with count at 2: no runt period
        set_div(5);
        for (int i = 1; i <= 11; i++) begin
            bus.div_load = (i == 3);
            bus.div_in   = 16'd3;
            @(negedge clk);
            check("reload strobe", bus.strobe, (i == 5 || i == 8 || i == 11) ? 1 : 0);
            check("reload div_cur", bus.div_cur, (i >= 5) ? 3 : 5);
        end
        bus.div_load = 1'b0;

        // SQUARE mode duty patterns
        bus.mode = MODE_SQUARE;
        set_div(5);
        check_seq("square N5", 10, 16'b00_0010_0001, 16'b00_1110_0111);
        set_div(4);
        check_seq("square N4", 8, 16'b0001_0001, 16'b0011_0011);
        set_div(0);
        check_seq("square N0", 4, 16'b1111, 16'b1111);
        set_div(1);
        check_seq("square N1", 4, 16'b1111, 16'b1111);

        // Reserved mode runs as PULSE
        bus.mode = MODE_RESERVED;
        set_div(3);
        check_seq("reserved N3", 6, 16'b00_1001, 16'b01_1011);

        // Enable hold stretches the period; sync restarts the phase
        bus.mode = MODE_PULSE;
        set_div(6);
        for (int i = 1; i <= 19; i++) begin
            bus.enable = !(i >= 3 && i <= 6);
            bus.sync   = (i == 13);
            @(negedge clk);
            check("hold/sync strobe", bus.strobe, (i == 10 || i == 13 || i == 19) ? 1 : 0);
        end
        bus.enable = 1'b1;
        bus.sync   = 1'b0;

        // ONESHOT, N=4: single strobe Neff edges after start, retrigger ignored
        set_div(4);
        bus.mode = MODE_ONESHOT;
        bus.sync = 1'b1;        // sync is ignored while IDLE
        repeat (2) @(negedge clk);
        bus.sync = 1'b0;
        check("oneshot idle strobe", bus.strobe, 0);
        check("oneshot idle busy", bus.busy, 0);
        check("oneshot idle square", bus.square, 0);
        for (int i = 0; i <= 10; i++) begin
            bus.start = (i == 0 || i == 2);
            @(negedge clk);
            check("oneshot busy", bus.busy, (i <= 3) ? 1 : 0);
            check("oneshot strobe", bus.strobe, (i == 4) ? 1 : 0);
        end
        bus.start = 1'b0;

        // Reset mid-countdown with a staged 9: staged value discarded
        bus.start = 1'b1;
        @(negedge clk);
        bus.start    = 1'b0;
        bus.div_in   = 16'd9;
        bus.div_load = 1'b1;
        @(negedge clk);
        bus.div_load = 1'b0;
        reset        = 1'b1;
        repeat (2) @(negedge clk);
        check("midreset strobe", bus.strobe, 0);
        check("midreset square", bus.square, 0);
        check("midreset busy", bus.busy, 0);
        check("midreset div_cur", bus.div_cur, DEF);
        reset    = 1'b0;
        bus.mode = MODE_PULSE;
        @(negedge clk);
        check_seq("post reset N2", 8, 16'b0101_0101, 16'b0101_0101);
        check("post reset div_cur", bus.div_cur, DEF);

        // Leaving ONESHOT mid-run resumes periodic counting from the count
        set_div(5);
        bus.mode = MODE_ONESHOT;
        for (int i = 0; i <= 7; i++) begin
            bus.mode  = (i < 2) ? MODE_ONESHOT : MODE_PULSE;
            bus.start = (i == 0);
            @(negedge clk);
            check("resume strobe", bus.strobe, (i == 5) ? 1 : 0);
        end
        bus.start = 1'b0;
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/strobe_divider.md
Name: strobe_divider

Overview:
- Runtime-programmable clock-enable/strobe generator; next generation of the fixed divide-by-N block.
- Adds: runtime divisor with glitch-free update, WIDTH parameter, enable/hold, phase resync, ~50% square output, one-shot mode.
- Feeds clock enables to UART baud ticks, LED PWM timebases and SPI/flash sequencers in the same clk domain.

Parameters:
- WIDTH, 16, width of the divisor and of the down-counter.
- DEFAULT_DIV, 2, divisor in effect after reset; must fit in WIDTH bits.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset; clock clk.
- enable  input  1  counting enable; 0 holds all state.
- mode  input  2  0=PULSE, 1=SQUARE, 2=ONESHOT, 3=reserved (behaves as PULSE).
- div_in  input  WIDTH  new divisor N.
- div_load  input  1  1-cycle request to stage div_in.
- start  input  1  ONESHOT trigger.
- sync  input  1  phase restart.
- strobe  output  1  1-cycle pulse per period (registered).
- square  output  1  ~50% duty output, valid in PULSE and SQUARE modes (registered).
- busy  output  1  ONESHOT countdown in progress; equals enable in other modes.
- div_cur  output  WIDTH  divisor currently in effect.

Behaviour:
- Reset: counter=0, div_cur=DEFAULT_DIV, pending=DEFAULT_DIV, pend_valid=0, strobe=0, square=0, oneshot state IDLE, busy=0. Reset mid-period discards the staged divisor.
- Effective divisor: Neff = max(div_cur, 1). N=0 is treated as 1.
- Terminal count (TC): counter==0 && enable.
  - On TC, strobe<=1 on the next edge.
  - Counter reloads Neff-1, using the pending divisor if pend_valid, which is then cleared.
  - Otherwise the counter decrements.
- Period: exactly Neff cycles between strobes. N=1 gives strobe high every enabled cycle.
- First strobe: one cycle after the first enabled cycle following reset.
- enable=0: counter, square and state hold; strobe=0; div_load is still accepted.
- div_load: pending<=div_in, pend_valid<=1. The new divisor applies only at the next TC, so there is no runt period. A second load before the TC overwrites the first. div_cur updates on the same edge as the reload.
- square:
  - High for ceil(Neff/2) cycles and low for floor(Neff/2) cycles.
  - Rising edge is coincident with strobe.
  - Neff=1 gives constant 1 while enabled.
  - Computed from the counter: high when counter >= Neff/2 after reload.
- sync (when enabled): forces an immediate TC, i.e. strobe next cycle and reload (pending applied).
  - Priority: reset > sync > normal count.
  - Ignored in ONESHOT IDLE.
- ONESHOT FSM, states IDLE and RUN:
  - IDLE: strobe=0, square=0, busy=0.
  - IDLE -> RUN on start&&enable. Counter loads Neff-1 (pending applied first), busy=1.
  - In RUN, the counter decrements. At counter==0, strobe pulses on the next edge and the FSM returns to IDLE. Latency from start to strobe is Neff cycles.
  - start while in RUN is ignored.
- Mode change takes effect on the next edge:
  - Entering ONESHOT forces IDLE.
  - Leaving ONESHOT resumes periodic counting from the current counter value.
- Arithmetic is unsigned WIDTH-bit. The counter never wraps below 0.

Decomposition:
- Shared package, strobe_pkg:
  - mode encodings MODE_PULSE, MODE_SQUARE, MODE_ONESHOT.
  - oneshot state typedef {IDLE, RUN}.
- Sub-module div_counter: down-counter with a reload port and TC output. The top level owns the divisor staging, output shaping and the FSM.

Test Plan:
- Reset, DEFAULT_DIV=2, PULSE, enable=1 -> strobe at cycles 1,3,5,7 after reset release; div_cur=2.
- N=5 loaded, then div_load N=3 at mid-period (counter=2) -> remaining strobe still spaced 5 cycles; following strobes spaced 3; div_cur changes 5->3 at that TC.
- SQUARE, N=5 -> square pattern 1,1,1,0,0 repeating, rising with strobe; N=4 -> 1,1,0,0; N=0 and N=1 -> strobe every cycle, square constant 1.
- enable low for 4 cycles mid-period with N=6 -> strobe spacing becomes 10; no strobe while disabled; sync pulse -> strobe exactly 1 cycle later, next strobe 6 cycles after that.
- ONESHOT, N=4, start at cycle t -> busy high t+1..t+4, single strobe at t+4, IDLE after; second start at t+2 ignored; no further strobes.
- Reset asserted mid-ONESHOT with a pending load of 9 -> all outputs 0; div_cur=DEFAULT_DIV; pending discarded (next periods use DEFAULT_DIV).
